// File: rtl/gate_checker.sv
// gate_checker: exhaustive tester for a two-input gate.
//
// Steps the gate inputs (a,b) through 00, 01, 10, 11, holding each vector for
// HOLD_CYCLES clocks. The gate response is sampled once per vector, on the
// last hold cycle, and compared against EXPECT_TABLE. After vector 3 the
// result is held in DONE until the next start or rst.
//
// Parameters:
//   HOLD_CYCLES   clocks each vector is held (2..255)
//   EXPECT_TABLE  bit i is the expected gate output for vector i
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   start      run request, honoured only in IDLE or DONE
//   dut_out    output of the gate under test
//   a, b       gate inputs (vector index bits 1 and 0)
//   busy       high while a run is in progress
//   done       high from run completion until next start or rst
//   pass       high iff the last run had no mismatches (valid with done)
//   err_count  number of mismatching vectors in the last run
//   fail_vec   bit i set iff vector i mismatched
module gate_checker #(
  parameter int unsigned HOLD_CYCLES  = 4,
  parameter logic [3:0]  EXPECT_TABLE = 4'b0001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_out,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam logic [7:0] HoldLast = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e     r_state;
  logic [1:0] r_idx;
  logic [7:0] r_hold;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [2:0] r_err;
  logic [3:0] r_fail;

  state_e     w_state_nxt;
  logic [1:0] w_idx_nxt;
  logic [7:0] w_hold_nxt;
  logic       w_busy_nxt;
  logic       w_done_nxt;
  logic       w_pass_nxt;
  logic [2:0] w_err_nxt;
  logic [3:0] w_fail_nxt;
  logic       w_mismatch;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_hold_nxt  = r_hold;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_pass_nxt  = r_pass;
    w_err_nxt   = r_err;
    w_fail_nxt  = r_fail;
    w_mismatch  = (dut_out != EXPECT_TABLE[r_idx]);

    unique case (r_state)
      StIdle, StDone: begin
        if (start) begin
          w_state_nxt = StDrive;
          w_idx_nxt   = 2'd0;
          w_hold_nxt  = 8'd0;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
          w_pass_nxt  = 1'b0;
          w_err_nxt   = 3'd0;
          w_fail_nxt  = 4'd0;
        end
      end
      StDrive: begin
        // start is deliberately ignored here so run timing never shifts.
        if (r_hold == HoldLast) begin
          if (w_mismatch) begin
            w_fail_nxt[r_idx] = 1'b1;
            w_err_nxt         = r_err + 3'd1;
          end
          w_hold_nxt = 8'd0;
          if (r_idx != 2'd3) begin
            w_idx_nxt = r_idx + 2'd1;
          end else begin
            // pass uses the updated count so a vector-3 mismatch is included.
            w_state_nxt = StDone;
            w_idx_nxt   = 2'd0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = (w_err_nxt == 3'd0);
          end
        end else begin
          w_hold_nxt = r_hold + 8'd1;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_idx   <= 2'd0;
      r_hold  <= 8'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= 3'd0;
      r_fail  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_hold  <= w_hold_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
      r_err   <= w_err_nxt;
      r_fail  <= w_fail_nxt;
    end
  end

  // The vector index register drives a and b directly, so both change together.
  assign a         = r_idx[1];
  assign b         = r_idx[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign fail_vec  = r_fail;

endmodule

// File: tb/tb_gate_checker.sv
// Self-checking bench for gate_checker with a result scoreboard.
module tb_gate_checker;

  localparam int unsigned H   = 4;
  localparam logic [3:0]  EXP = 4'b0001;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       dut_drv;
  logic       use_gate;
  logic       dut_out;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        pass;
    logic [2:0]  err;
    logic [3:0]  fail;
    int unsigned len;
  } exp_t;

  exp_t sb[$];

  // use_gate models a real NOR gate wired to the checker outputs.
  assign dut_out = use_gate ? ~(a | b) : dut_drv;

  always #5 clk = ~clk;

  gate_checker #(
    .HOLD_CYCLES  (H),
    .EXPECT_TABLE (EXP)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dut_out   (dut_out),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec)
  );

  // mode 0: NOR, 1: tied 0, 2: tied 1, 3: NOR on sample cycles, inverted otherwise
  function automatic logic gate_val(input int mode, input int v, input bit smp);
    logic nor_v;
    nor_v = (v == 0);
    case (mode)
      0:       return nor_v;
      1:       return 1'b0;
      2:       return 1'b1;
      default: return smp ? nor_v : ~nor_v;
    endcase
  endfunction

  function automatic exp_t model(input int mode);
    exp_t e;
    logic [3:0] tbl;
    tbl    = EXP;
    e.fail = 4'd0;
    e.err  = 3'd0;
    for (int v = 0; v < 4; v++) begin
      if (gate_val(mode, v, 1'b1) !== tbl[v]) begin
        e.fail[v] = 1'b1;
        e.err     = e.err + 3'd1;
      end
    end
    e.pass = (e.err == 3'd0);
    e.len  = 4 * H;
    return e;
  endfunction

  // One full run; start is re-asserted during busy cycles p1 and p2 (0 = never).
  task automatic do_run(input int mode, input int p1, input int p2, input string tag);
    exp_t e;
    int   c;
    int   v;
    bit   got;
    sb.push_back(model(mode));
    use_gate = 1'b0;
    dut_drv  = gate_val(mode, 0, 1'b0);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c     = 0;
    got   = 1'b0;
    while (!got && c < 4 * H + 20) begin
      if (done === 1'b1) begin
        got = 1'b1;
      end else begin
        c++;
        v = (c - 1) / H;
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s busy c%0d: got %b want 1", tag, c, busy);
        end
        if (v < 4) begin
          n_checks++;
          if ({a, b} !== 2'(v)) begin
            n_fail++;
            $display("FAIL %s ab c%0d: got %b%b want %0d", tag, c, a, b, v);
          end
        end
        dut_drv = gate_val(mode, v, (c % H) == 0);
        start   = (c == p1) || (c == p2);
        @(negedge clk);
      end
    end
    start = 1'b0;
    n_checks++;
    if (!got || sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s timeout: got done=%b want 1", tag, done);
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (c !== int'(e.len)) begin
        n_fail++;
        $display("FAIL %s busy_len: got %0d want %0d", tag, c, e.len);
      end
      n_checks++;
      if (pass !== e.pass) begin
        n_fail++;
        $display("FAIL %s pass: got %b want %b", tag, pass, e.pass);
      end
      n_checks++;
      if (err_count !== e.err) begin
        n_fail++;
        $display("FAIL %s err_count: got %0d want %0d", tag, err_count, e.err);
      end
      n_checks++;
      if (fail_vec !== e.fail) begin
        n_fail++;
        $display("FAIL %s fail_vec: got %b want %b", tag, fail_vec, e.fail);
      end
      n_checks++;
      if ({busy, a, b} !== 3'b000) begin
        n_fail++;
        $display("FAIL %s busy_ab_done: got %b%b%b want 000", tag, busy, a, b);
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({a, b, busy, done, pass, err_count, fail_vec} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0",
               {a, b, busy, done, pass, err_count, fail_vec});
    end
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: got busy/done %b%b want 00", busy, done);
    end
  endtask

  task automatic test_nor();
    do_run(0, 0, 0, "nor");
  endtask

  task automatic test_tied0();
    do_run(1, 0, 0, "tied0");
  endtask

  task automatic test_tied1();
    do_run(2, 0, 0, "tied1");
    repeat (3) @(negedge clk);
    n_checks++;
    if ({done, pass, err_count, fail_vec} !== {1'b1, 1'b0, 3'd3, 4'b1110}) begin
      n_fail++;
      $display("FAIL done_hold: got %b want %b", {done, pass, err_count, fail_vec},
               {1'b1, 1'b0, 3'd3, 4'b1110});
    end
  endtask

  task automatic test_rst_mid();
    use_gate = 1'b0;
    start    = 1'b1;
    dut_drv  = gate_val(0, 0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 6; c++) begin
      dut_drv = gate_val(0, (c - 1) / H, (c % H) == 0);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({a, b, busy, done, pass, err_count, fail_vec} !== 12'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %b want 0",
               {a, b, busy, done, pass, err_count, fail_vec});
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_no_resume: got busy=%b want 0", busy);
    end
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_over_start: got busy=%b want 0", busy);
    end
    do_run(0, 0, 0, "after_rst");
  endtask

  task automatic test_start_ignored();
    do_run(3, 3, 9, "start_ignored");
  endtask

  task automatic test_back_to_back();
    int c;
    do_run(1, 0, 0, "pre_b2b");
    use_gate = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, err_count, fail_vec} !== {1'b1, 1'b0, 3'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL b2b_restart: got %b want %b", {busy, done, err_count, fail_vec},
               {1'b1, 1'b0, 3'd0, 4'd0});
    end
    for (int r = 0; r < 3; r++) begin
      if (r == 2) start = 1'b0;
      c = 0;
      while (done !== 1'b1 && c < 100) begin
        c++;
        @(negedge clk);
      end
      n_checks++;
      if (c !== int'(4 * H)) begin
        n_fail++;
        $display("FAIL b2b_len r%0d: got %0d want %0d", r, c, 4 * H);
      end
      n_checks++;
      if ({pass, err_count, fail_vec} !== {1'b1, 3'd0, 4'd0}) begin
        n_fail++;
        $display("FAIL b2b_result r%0d: got %b want %b", r, {pass, err_count, fail_vec},
                 {1'b1, 3'd0, 4'd0});
      end
      @(negedge clk);
      n_checks++;
      if (r < 2 && {done, busy} !== 2'b01) begin
        n_fail++;
        $display("FAIL b2b_done_pulse r%0d: got done/busy %b%b want 01", r, done, busy);
      end else if (r == 2 && {done, busy} !== 2'b10) begin
        n_fail++;
        $display("FAIL b2b_stop: got done/busy %b%b want 10", done, busy);
      end
    end
    use_gate = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dut_drv  = 1'b0;
    use_gate = 1'b0;
    test_reset();
    test_nor();
    test_tied0();
    test_tied1();
    test_rst_mid();
    test_start_ignored();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_checker.md
GATE_CHECKER -- requirements
Module: gate_checker

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4: clock cycles each input vector is held; legal range 2..255.
REQ-002 SHALL have parameter EXPECT_TABLE, default 4'b0001: bit i is the expected dut_out for vector i; the default is the NOR truth table.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  run request, sampled only in IDLE or DONE.
REQ-006 SHALL have port dut_out  input  1  output of the gate under test.
REQ-007 SHALL have port a  output  1  gate input a; equals vector index bit 1.
REQ-008 SHALL have port b  output  1  gate input b; equals vector index bit 0.
REQ-009 SHALL have port busy  output  1  high while a run is in progress.
REQ-010 SHALL have port done  output  1  high from run completion until the next start or rst.
REQ-011 SHALL have port pass  output  1  valid when done=1; high iff err_count==0.
REQ-012 SHALL have port err_count  output  3  number of mismatching vectors in the last run, 0..4.
REQ-013 SHALL have port fail_vec  output  4  bit i set iff vector i mismatched.

Function
REQ-014 SHALL implement the states IDLE, DRIVE and DONE.
REQ-015 SHALL go from IDLE or DONE to DRIVE on the edge where start=1, and on that edge SHALL set:
- a=0, b=0 (vector 0)
- hold counter = 0
- busy=1, done=0, pass=0
- err_count=0, fail_vec=0
REQ-016 SHALL apply vectors in the order 0,1,2,3, i.e. (a,b) = 00, 01, 10, 11.
REQ-017 SHALL hold each vector for exactly HOLD_CYCLES cycles; the hold counter increments each DRIVE cycle.
REQ-018 SHALL sample dut_out only on the edge where the hold counter equals HOLD_CYCLES-1; dut_out SHALL be ignored on all other cycles.
REQ-019 SHALL treat a sample as a mismatch when dut_out != EXPECT_TABLE[index]. On a mismatch, the same edge SHALL set fail_vec[index] and increment err_count.
REQ-020 SHALL, on a sample edge with index<3, advance the index, drive the new vector on the same edge, and clear the hold counter.
REQ-021 SHALL, on the sample edge of vector 3, take all of the following actions on that same edge:
- enter DONE
- set busy=0, done=1
- set pass = (final err_count==0), including a vector-3 mismatch
- return a,b to 00
REQ-022 SHALL keep busy high for exactly 4*HOLD_CYCLES cycles per run.
REQ-023 SHALL ignore start while in DRIVE; the run timing SHALL be unchanged.
REQ-024 SHALL hold err_count, fail_vec and pass stable in DONE until the next start or rst.
REQ-025 SHALL let start=1 in DONE begin a new run on that edge; start held high SHALL give back-to-back runs, with done high for one cycle between them.
REQ-026 SHALL never let err_count exceed 4; no saturation logic is needed beyond the 3-bit width.
REQ-027 SHALL drive a,b only from registers, so both change on the same edge and neither glitches relative to the other.

Reset
REQ-028 SHALL, on any edge with rst=1, enter IDLE and set a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, hold counter=0, index=0.
REQ-029 SHALL give rst priority over start and over any in-progress DRIVE activity; a run interrupted by rst SHALL NOT resume.
REQ-030 SHALL start no run while rst=1, even if start=1.

Verification
REQ-031 dut_out = ~(a|b), HOLD_CYCLES=4, one-cycle start pulse -> busy high 16 cycles; (a,b) steps 00,01,10,11 every 4 cycles; then done=1, pass=1, err_count=0, fail_vec=0000.
REQ-032 dut_out tied 0 -> done=1, pass=0, err_count=1, fail_vec=0001.
REQ-033 dut_out tied 1 -> done=1, pass=0, err_count=3, fail_vec=1110.
REQ-034 rst=1 for one cycle at busy cycle 6 -> next edge all outputs zero, state IDLE; a following start yields the REQ-031 result exactly.
REQ-035 start re-pulsed at busy cycles 3 and 9; dut_out wrong on every non-sample cycle but correct on sample edges -> single run, done after 16 cycles, pass=1, err_count=0.
REQ-036 start held high continuously with a correct gate -> consecutive runs; done high exactly one cycle between runs; err_count and fail_vec cleared at each restart.
